data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//  Slave end of the CPU data-side SRAM-like interface (req/addr_ok/data_ok). Accepts
//  load/store requests from EX, holds up to DEPTH outstanding, returns data_ok/rdata
//  in order to MEM. Backed by an internal word RAM. Used as the bench memory model.
// PARAMETERS
//  RAM_AW  10  word-address width of internal RAM (2^RAM_AW x 32-bit words)
//  DEPTH    4  max outstanding requests (power of 2, >=2)
//  LAT      2  cycles from accept to earliest data_ok (>=1)
// PORTS
//  clk                input   1  clock, rising edge
//  reset              input   1  asynchronous, active-high
//  data_sram_req      input   1  request valid
//  data_sram_wr       input   1  1=store, 0=load
//  data_sram_size     input   2  0=byte, 1=half, 2=word (3 treated as word)
//  data_sram_addr     input  32  byte address; word index = addr[RAM_AW+1:2]
//  data_sram_wdata    input  32  store data, already lane-aligned by EX
//  data_sram_addr_ok  output  1  request accepted this cycle when req&&addr_ok
//  data_sram_data_ok  output  1  one-cycle pulse per completed request
//  data_sram_rdata    output 32  full RAM word; valid only with data_ok
// BEHAVIOUR
//  Reset (async): count=0, FIFO rd/wr ptrs=0, all entry valids=0 -> data_ok=0,
//   rdata=0, addr_ok=1 once reset deasserts. RAM contents are NOT reset.
//  addr_ok = (count < DEPTH); combinational from registers only, never depends on
//   req. No same-cycle bypass: a full FIFO rejects even if head pops that cycle.
//  Accept (req && addr_ok, cycle T):
//   - store: strobe byte: 4'b0001<<addr[1:0]; half: 4'b0011<<{addr[1],1'b0};
//     word: 4'b1111. Misaligned (half addr[0]=1, word addr[1:0]!=0): strobe=0,
//     RAM untouched, request still queued and answered.
//   - RAM written at end of T; load reads RAM word at T (sees every store accepted
//     before T; accepts are strictly ordered, so RAW across queued entries is safe).
//   - entry pushed {rdata (0 for store), cnt=LAT-1}.
//  Each cycle every valid entry with cnt!=0 decrements; cnt saturates at 0.
//  data_ok = head valid && head cnt==0; rdata = head data (0 when !data_ok).
//   Head pops on the same edge; next entry may pulse data_ok the following cycle.
//  Latency: isolated request accepted at T -> data_ok in cycle T+LAT. Behind a
//   busy head: data_ok = max(T+LAT, prev data_ok cycle + 1). Strict request order.
//  count: +1 on accept, -1 on pop, unchanged when both in the same cycle.
//   Pointers wrap modulo DEPTH.
//  No flush input: requests already accepted are always answered; the CPU
//   discards stale responses.
//  Reset mid-operation: queued entries dropped, data_ok deasserts asynchronously;
//   stores accepted before reset remain in RAM.
//  req with addr_ok=0: ignored, no state change. X on inputs when req=0: ignored.
// TESTING
//  1 LAT=2: store word 0x12345678 @0x100 at T, load @0x100 at T+1 -> data_ok
//    T+2 (rdata=0), T+3 rdata=0x12345678.
//  2 Then store byte @0x101 wdata=0x0000AB00, load @0x100 -> rdata=0x1234AB78;
//    store half @0x102 wdata=0xBEEF0000 -> next load 0xBEEFAB78.
//  3 LAT=8,DEPTH=4: loads every cycle T..T+4 -> addr_ok low at T+4, high again
//    T+9; data_ok pulses T+8..T+11 back-to-back, 5th at T+12 or later, in order.
//  4 Misaligned half store @0x103 and word store @0x102 -> RAM unchanged (reload
//    returns prior value); both still produce one data_ok each.
//  5 Three loads outstanding, assert reset 1 cycle -> data_ok=0 immediately,
//    no stale pulses after release, addr_ok=1, earlier stores still readable.
//  6 LAT=1 continuous alternating store/load stream, 64 requests -> addr_ok never
//    drops, exactly 64 data_ok, each load matches a scoreboard RAM model.

Source files
------------

// File: rtl/data_sram_responder.sv
// Slave end of the CPU data-side SRAM-like interface: in-order request FIFO with fixed
// minimum latency, backed by an internal byte-writable word RAM.
module data_sram_responder #(
    parameter int unsigned RAM_AW = 10,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [PW:0] DepthW = DEPTH[PW:0];
    localparam logic [CW-1:0] CntInit = CW'(LAT - 1);

    logic [31:0]      mem [1 << RAM_AW];

    logic [PW:0]      count_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    cnt_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic              accept;
    logic              pop;
    logic [3:0]        strobe;
    logic [RAM_AW-1:0] word_idx;
    logic              unused_addr;

    assign word_idx    = data_sram_addr[RAM_AW+1:2];
    assign unused_addr = ^data_sram_addr[31:RAM_AW+2];

    // Fullness is judged on registered count only; a same-cycle pop never frees a slot.
    assign data_sram_addr_ok = (count_q < DepthW);
    assign accept            = data_sram_req && data_sram_addr_ok;

    assign data_sram_data_ok = valid_q[rd_ptr_q] && (cnt_q[rd_ptr_q] == '0);
    assign data_sram_rdata   = data_sram_data_ok ? data_q[rd_ptr_q] : 32'h0;
    assign pop               = data_sram_data_ok;

    // Misaligned half/word stores get an empty strobe but are still queued.
    always_comb begin
        strobe = 4'b0000;
        unique case (data_sram_size)
            2'd0: strobe = 4'b0001 << data_sram_addr[1:0];
            2'd1: strobe = data_sram_addr[0] ? 4'b0000
                                             : (4'b0011 << {data_sram_addr[1], 1'b0});
            default: strobe = (data_sram_addr[1:0] != 2'b00) ? 4'b0000 : 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && accept && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i]  <= '0;
                data_q[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            // Push slot is always free here: accept implies not full, pop implies not empty.
            if (accept) begin
                valid_q[wr_ptr_q] <= 1'b1;
                cnt_q[wr_ptr_q]   <= CntInit;
                data_q[wr_ptr_q]  <= data_sram_wr ? 32'h0 : mem[word_idx];
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised and directed bench for data_sram_responder against an in-order response
// schedule and byte-lane RAM model.
module tb_data_sram_responder;

    localparam int TB_AW    = 10;
    localparam int TB_DEPTH = 4;
    localparam int TB_LAT   = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_sram_req = 1'b0;
    logic        data_sram_wr = 1'b0;
    logic [1:0]  data_sram_size = 2'd0;
    logic [31:0] data_sram_addr = 32'h0;
    logic [31:0] data_sram_wdata = 32'h0;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    data_sram_responder #(
        .RAM_AW(TB_AW),
        .DEPTH (TB_DEPTH),
        .LAT   (TB_LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .data_sram_req    (data_sram_req),
        .data_sram_wr     (data_sram_wr),
        .data_sram_size   (data_sram_size),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } obs_t;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_due = -1000;
    ent_t        model_q[$];
    obs_t        obs_q[$];
    logic [31:0] mem_m [1 << TB_AW];
    logic        exp_aok;
    logic        exp_ok;
    logic [31:0] exp_rd;
    int          due;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Store as seen by memory: which bytes change follows only size and alignment.
    function automatic void model_store(input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] wdata);
        int lo;
        int n;
        lo = int'(addr[1:0]);
        n  = 0;
        if (size == 2'd0) n = 1;
        else if (size == 2'd1) n = (addr[0] == 1'b0) ? 2 : 0;
        else n = (addr[1:0] == 2'b00) ? 4 : 0;
        for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + n) mem_m[addr[TB_AW+1:2]][8*b +: 8] = wdata[8*b +: 8];
        end
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            model_q.delete();
            last_due = -1000;
            check("data_ok in reset", {31'b0, data_sram_data_ok}, 32'd0);
            check("rdata in reset", data_sram_rdata, 32'h0);
        end else begin
            exp_aok = (model_q.size() < TB_DEPTH);
            exp_ok  = (model_q.size() != 0) && (model_q[0].due <= cyc);
            exp_rd  = exp_ok ? model_q[0].data : 32'h0;
            check("addr_ok", {31'b0, data_sram_addr_ok}, {31'b0, exp_aok});
            check("data_ok", {31'b0, data_sram_data_ok}, {31'b0, exp_ok});
            check("rdata", data_sram_rdata, exp_rd);
            if (data_sram_data_ok) obs_q.push_back('{cyc: cyc, data: data_sram_rdata});
            if (exp_ok) void'(model_q.pop_front());
            if (data_sram_req && exp_aok) begin
                due = (cyc + TB_LAT > last_due + 1) ? cyc + TB_LAT : last_due + 1;
                last_due = due;
                if (data_sram_wr) begin
                    model_q.push_back('{data: 32'h0, due: due});
                    model_store(data_sram_size, data_sram_addr, data_sram_wdata);
                end else begin
                    model_q.push_back('{data: mem_m[data_sram_addr[TB_AW+1:2]], due: due});
                end
            end
        end
    end

    function automatic int obs_cyc(input int i);
        return (i < obs_q.size()) ? obs_q[i].cyc : -1;
    endfunction

    function automatic logic [31:0] obs_dat(input int i);
        return (i < obs_q.size()) ? obs_q[i].data : 32'hDEAD_DEAD;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output int acc);
        int n;
        data_sram_req   = 1'b1;
        data_sram_wr    = wr;
        data_sram_size  = size;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        n = 0;
        acc = -1;
        while (n < 60) begin
            @(negedge clk);
            if (data_sram_addr_ok) break;
            n++;
        end
        if (n >= 60) check("accept timeout", 32'd0, 32'd1);
        else acc = cyc;
        @(posedge clk);
        #1;
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'($urandom);
        data_sram_size  = 2'($urandom);
        data_sram_addr  = $urandom;
        data_sram_wdata = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (model_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", model_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    int t[5];
    int n_acc;
    int n_wait;

    initial begin
        #1;
        check("reset data_ok", {31'b0, data_sram_data_ok}, 32'd0);
        check("reset rdata", data_sram_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("addr_ok after reset", {31'b0, data_sram_addr_ok}, 32'd1);

        for (int i = 0; i < 128; i++) issue(1'b1, 2'd2, 32'(i * 4), $urandom, t[0]);
        drain();

        // Store then load of the same word, back to back.
        obs_q.delete();
        issue(1'b1, 2'd2, 32'h100, 32'h1234_5678, t[0]);
        issue(1'b0, 2'd2, 32'h100, 32'h0, t[1]);
        drain();
        check("t1 accept gap", 32'(t[1] - t[0]), 32'd1);
        check("t1 store ok cycle", 32'(obs_cyc(0) - t[0]), 32'(TB_LAT));
        check("t1 store rdata", obs_dat(0), 32'h0);
        check("t1 load ok cycle", 32'(obs_cyc(1) - t[0]), 32'(TB_LAT + 1));
        check("t1 load rdata", obs_dat(1), 32'h1234_5678);

        obs_q.delete();
        issue(1'b1, 2'd0, 32'h101, 32'h0000_AB00, t[0]);
        issue(1'b0, 2'd2, 32'h100, 32'h0, t[0]);
        issue(1'b1, 2'd1, 32'h102, 32'hBEEF_0000, t[0]);
        issue(1'b0, 2'd2, 32'h100, 32'h0, t[0]);
        drain();
        check("t2 byte merge", obs_dat(1), 32'h1234_AB78);
        check("t2 half merge", obs_dat(3), 32'hBEEF_AB78);

        obs_q.delete();
        issue(1'b1, 2'd1, 32'h103, 32'hFFFF_FFFF, t[0]);
        issue(1'b1, 2'd2, 32'h102, 32'hFFFF_FFFF, t[0]);
        issue(1'b0, 2'd2, 32'h100, 32'h0, t[0]);
        drain();
        check("t4 responses", obs_q.size(), 32'd3);
        check("t4 misaligned untouched", obs_dat(2), 32'hBEEF_AB78);

        // Five loads as fast as the FIFO allows: the fifth is held off until the first pop.
        obs_q.delete();
        for (int i = 0; i < 5; i++) issue(1'b0, 2'd2, 32'h100, 32'h0, t[i]);
        drain();
        check("t3 fourth accept", 32'(t[3] - t[0]), 32'd3);
        check("t3 fifth accept", 32'(t[4] - t[0]), 32'(TB_LAT + 1));
        for (int i = 0; i < 4; i++) check("t3 ok cycle", 32'(obs_cyc(i) - t[0]), 32'(TB_LAT + i));
        check("t3 fifth ok cycle", 32'(obs_cyc(4) - t[0]), 32'(2 * TB_LAT + 1));
        check("t3 fifth rdata", obs_dat(4), 32'hBEEF_AB78);

        // Reset with three loads outstanding, asserted while the head is presenting data.
        for (int i = 0; i < 3; i++) issue(1'b0, 2'd2, 32'h100, 32'h0, t[i]);
        n_wait = 0;
        while (cyc != t[0] + TB_LAT && n_wait < 20) begin
            @(posedge clk);
            #1;
            n_wait++;
        end
        check("t5 head ready", {31'b0, data_sram_data_ok}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5 async data_ok", {31'b0, data_sram_data_ok}, 32'd0);
        check("t5 async rdata", data_sram_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5 addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
        obs_q.delete();
        repeat (12) @(posedge clk);
        #1;
        check("t5 no stale", obs_q.size(), 32'd0);
        issue(1'b0, 2'd2, 32'h100, 32'h0, t[0]);
        drain();
        check("t5 ram kept", obs_dat(0), 32'hBEEF_AB78);

        // Random mixed traffic with idle gaps carrying junk on the request fields.
        obs_q.delete();
        n_acc = 0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                data_sram_addr = $urandom;
                data_sram_wr   = 1'($urandom);
                @(posedge clk);
                #1;
            end
            issue((i % 2) == 0 ? 1'b1 : 1'($urandom), 2'($urandom_range(0, 3)),
                  32'($urandom_range(0, 511)), $urandom, t[0]);
            if (t[0] >= 0) n_acc++;
        end
        drain();
        check("random response count", obs_q.size(), 32'(n_acc));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
